// File: rtl/hsp_obi_mem_lat.sv
// hsp_obi_mem_lat: OBI slave memory model with byte-enable writes over a sparse pattern store,
// fixed response latency, an outstanding cap and run-time selectable grant behaviour.
module hsp_obi_mem_lat #(
    parameter int          WORD_WIDTH       = 32,
    parameter int          DATA_WIDTH       = 16,
    parameter logic [31:0] VALUE_MASK       = 32'hFFFF,
    parameter int          VALUE_MODULE_LSB = 13,
    parameter int          VALUE_MODULE_MSB = 17,
    parameter int          DEPTH            = 256,
    parameter int          RSP_LATENCY      = 2,
    parameter int          MAX_OUTSTANDING  = 2,
    parameter logic [15:0] LFSR_SEED        = 16'hACE1,
    parameter int          STALL_PERIOD     = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_obi_req,
    input  logic                    i_obi_we,
    input  logic [WORD_WIDTH/8-1:0] i_obi_be,
    input  logic [WORD_WIDTH-1:0]   i_obi_addr,
    input  logic [WORD_WIDTH-1:0]   i_obi_wdata,
    output logic                    o_obi_gnt,
    output logic                    o_obi_rvalid,
    output logic [WORD_WIDTH-1:0]   o_obi_rdata,
    input  logic [1:0]              i_gnt_mode,
    output logic [31:0]             o_rd_count,
    output logic [31:0]             o_wr_count,
    output logic [31:0]             o_stall_count
);
    localparam int IW = $clog2(DEPTH);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int SW = STALL_PERIOD > 1 ? $clog2(STALL_PERIOD) : 1;

    logic [WORD_WIDTH-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0]      r_val;
    logic [RSP_LATENCY-1:0] r_dv;
    logic [WORD_WIDTH-1:0] r_dd [RSP_LATENCY];
    logic [OW-1:0]         r_out;
    logic [15:0]           r_lfsr;
    logic [SW-1:0]         r_stall;
    logic [31:0]           r_rd, r_wr, r_st;
    logic [IW-1:0]         w_idx;
    logic [31:0]           w_key;
    logic [WORD_WIDTH-1:0] w_pat, w_cur, w_wr;
    logic                  w_mode_ok, w_acc, w_unused;

    assign w_idx = i_obi_addr[2 +: IW];
    assign w_key = 32'(i_obi_addr[DATA_WIDTH-1:0]) & VALUE_MASK;
    assign w_pat = WORD_WIDTH'({DATA_WIDTH'(w_key % 32'(VALUE_MODULE_MSB)),
                                DATA_WIDTH'(w_key % 32'(VALUE_MODULE_LSB))});
    assign w_cur = r_val[w_idx] ? r_mem[w_idx] : w_pat;
    assign w_unused = ^i_obi_addr;

    always_comb begin
        w_wr = w_cur;
        for (int b = 0; b < WORD_WIDTH / 8; b++)
            if (i_obi_be[b]) w_wr[8*b +: 8] = i_obi_wdata[8*b +: 8];
    end

    assign w_mode_ok = i_gnt_mode == 2'd0 ? 1'b1 :
                       i_gnt_mode == 2'd1 ? r_lfsr[0] :
                       i_gnt_mode == 2'd2 ? (r_stall != SW'(STALL_PERIOD - 1)) : 1'b0;
    // The cap uses the registered count, so a retiring response never frees a same-cycle slot.
    assign o_obi_gnt = !rst && i_obi_req && (r_out < OW'(MAX_OUTSTANDING)) && w_mode_ok;
    assign w_acc = o_obi_gnt;

    always_ff @(posedge clk)
        if (w_acc && i_obi_we) r_mem[w_idx] <= w_wr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_val   <= '0;
            r_dv    <= '0;
            for (int i = 0; i < RSP_LATENCY; i++) r_dd[i] <= '0;
            r_out   <= '0;
            r_lfsr  <= LFSR_SEED;
            r_stall <= '0;
            r_rd    <= '0;
            r_wr    <= '0;
            r_st    <= '0;
        end else begin
            if (w_acc && i_obi_we) r_val[w_idx] <= 1'b1;
            r_dv[0] <= w_acc;
            r_dd[0] <= (w_acc && !i_obi_we) ? w_cur : '0;
            for (int i = 1; i < RSP_LATENCY; i++) begin
                r_dv[i] <= r_dv[i-1];
                r_dd[i] <= r_dd[i-1];
            end
            r_out <= r_out + OW'(w_acc) - OW'(o_obi_rvalid);
            if (i_obi_req) r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
            if (i_obi_req && i_gnt_mode == 2'd2)
                r_stall <= (r_stall == SW'(STALL_PERIOD - 1)) ? '0 : r_stall + 1'b1;
            r_rd <= r_rd + 32'(w_acc && !i_obi_we && r_rd != '1);
            r_wr <= r_wr + 32'(w_acc && i_obi_we && r_wr != '1);
            r_st <= r_st + 32'(i_obi_req && !o_obi_gnt && r_st != '1);
        end
    end

    assign o_obi_rvalid  = r_dv[RSP_LATENCY-1];
    assign o_obi_rdata   = r_dd[RSP_LATENCY-1];
    assign o_rd_count    = r_rd;
    assign o_wr_count    = r_wr;
    assign o_stall_count = r_st;
endmodule

// File: tb/tb_hsp_obi_mem_lat.sv
// tb_hsp_obi_mem_lat: directed scenarios plus randomized traffic against a queue/array reference model.
module tb_hsp_obi_mem_lat;
    localparam int LAT = 3, MAXO = 2, DEP = 16, SP = 4;

    logic        clk = 0, rst = 1, req = 0, we = 0;
    logic [3:0]  be = '0;
    logic [31:0] addr = '0, wdata = '0;
    logic [1:0]  mode = '0;
    logic        gnt, rvalid;
    logic [31:0] rdata, rd_cnt, wr_cnt, st_cnt;
    int          total = 0, bad = 0;

    always #5 clk = ~clk;

    hsp_obi_mem_lat #(
        .DEPTH(DEP), .RSP_LATENCY(LAT), .MAX_OUTSTANDING(MAXO), .STALL_PERIOD(SP)
    ) dut (
        .clk(clk), .rst(rst),
        .i_obi_req(req), .i_obi_we(we), .i_obi_be(be), .i_obi_addr(addr), .i_obi_wdata(wdata),
        .o_obi_gnt(gnt), .o_obi_rvalid(rvalid), .o_obi_rdata(rdata),
        .i_gnt_mode(mode),
        .o_rd_count(rd_cnt), .o_wr_count(wr_cnt), .o_stall_count(st_cnt)
    );

    typedef struct {int due; logic [31:0] d;} ent_t;
    ent_t        q[$];
    logic [31:0] mem [int];
    logic [15:0] lfsr = 16'hACE1;
    int          sc = 0, cyc = 0;
    logic [31:0] m_rd = 0, m_wr = 0, m_st = 0, last_rd = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d: got %h want %h", tag, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] a);
        int k;
        int idx;
        k = int'(a & 32'hFFFF);
        idx = int'(a >> 2) % DEP;
        if (mem.exists(idx)) return mem[idx];
        return 32'(((k % 17) << 16) | (k % 13));
    endfunction

    task automatic step(input logic rq, input logic w, input logic [3:0] b, input logic [31:0] a,
                        input logic [31:0] wd, input logic [1:0] md, input logic rs);
        logic ok, eg, erv;
        logic [31:0] cur;
        @(posedge clk);
        #1;
        rst = rs; req = rq; we = w; be = b; addr = a; wdata = wd; mode = md;
        #4;
        ok  = md == 0 ? 1'b1 : md == 1 ? lfsr[0] : md == 2 ? (sc != SP - 1) : 1'b0;
        eg  = !rs && rq && q.size() < MAXO && ok;
        erv = q.size() > 0 && q[0].due == cyc;
        chk("gnt", 32'(gnt), 32'(eg));
        chk("rvalid", 32'(rvalid), 32'(erv));
        if (erv) chk("rdata", rdata, q[0].d);
        chk("rd_count", rd_cnt, m_rd);
        chk("wr_count", wr_cnt, m_wr);
        chk("stall_count", st_cnt, m_st);
        last_rd = rdata;
        if (erv) void'(q.pop_front());
        if (rs) begin
            q.delete(); mem.delete();
            lfsr = 16'hACE1; sc = 0; m_rd = 0; m_wr = 0; m_st = 0;
        end else begin
            if (eg) begin
                cur = model_read(a);
                if (w) begin
                    for (int i = 0; i < 4; i++) if (b[i]) cur[8*i +: 8] = wd[8*i +: 8];
                    mem[int'(a >> 2) % DEP] = cur;
                    q.push_back('{cyc + LAT, 32'h0});
                    m_wr++;
                end else begin
                    q.push_back('{cyc + LAT, cur});
                    m_rd++;
                end
            end
            if (rq && !eg) m_st++;
            if (rq) lfsr = (lfsr >> 1) ^ (lfsr[0] ? 16'hB400 : 16'h0000);
            if (rq && md == 2) sc = (sc + 1) % SP;
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 4'h0, 32'h0, 32'h0, 2'd0, 0);
    endtask

    initial begin
        logic [1:0] md;
        repeat (2) @(posedge clk);
        step(0, 0, 4'h0, 32'h0, 32'h0, 2'd0, 1);
        step(1, 0, 4'hF, 32'h10, 32'h0, 2'd0, 0);
        idle(3);
        chk("t1_rdata", last_rd, 32'h0010_0003);
        step(1, 1, 4'b0011, 32'h20, 32'hDEADBEEF, 2'd0, 0);
        step(1, 0, 4'hF, 32'h20, 32'h0, 2'd0, 0);
        idle(2);
        chk("t2_wr_rsp", last_rd, 32'h0);
        idle(1);
        chk("t2_rdata", last_rd, 32'h000F_BEEF);
        step(1, 0, 4'hF, 32'h40, 32'h0, 2'd0, 0);
        step(1, 0, 4'hF, 32'h44, 32'h0, 2'd0, 0);
        step(0, 0, 4'h0, 32'h0, 32'h0, 2'd0, 1);
        idle(4);
        step(1, 0, 4'hF, 32'h20, 32'h0, 2'd0, 0);
        idle(3);
        chk("t6_rdata", last_rd, 32'h000F_0006);
        for (int i = 0; i < 12; i++) step(1, 0, 4'hF, 32'(i * 4), 32'h0, 2'd2, 0);
        for (int i = 0; i < 24; i++) step(1, 0, 4'hF, 32'(i * 4), 32'h0, 2'd1, 0);
        for (int i = 0; i < 4; i++) step(1, 0, 4'hF, 32'h0, 32'h0, 2'd3, 0);
        md = 2'd0;
        for (int n = 0; n < 3000; n++) begin
            if (n % 60 == 0) md = $urandom_range(0, 9) == 0 ? 2'd3 : 2'($urandom_range(0, 2));
            step($urandom_range(0, 3) != 0, $urandom_range(0, 9) < 4, 4'($urandom),
                 $urandom_range(0, 9) == 0 ? $urandom : 32'($urandom_range(0, 255)),
                 $urandom, md, $urandom_range(0, 99) == 0);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
